// File: rtl/reg_arbiter_pkg.sv
// rtl/reg_arbiter_pkg.sv - shared constants and FSM encoding for the register arbiter
package reg_arbiter_pkg;

  localparam int          MAX_REQ       = 4;
  localparam int          IDX_W         = $clog2(MAX_REQ);
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/reg_arbiter_rr_pick.sv
// rtl/reg_arbiter_rr_pick.sv - combinational round-robin selector
// Searches from last_grant+1 upward, wrapping modulo the requester count.
module rr_pick
  import reg_arbiter_pkg::*;
#(
  parameter int N_REQ_P = 2
) (
  input  logic [N_REQ_P-1:0] req_vec,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  int cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      if (off <= N_REQ_P) begin
        cand = (int'(last_grant) + off) % N_REQ_P;
        if (!valid && |(req_vec & (N_REQ_P'(1) << cand))) begin
          valid = 1'b1;
          index = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - round-robin arbiter from N requesters onto one register bus
// One transaction in flight; completion by downstream ack or by a cycle timeout.
module reg_arbiter
  import reg_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE_P = 4,
  parameter int N_REQ_P     = 2,
  parameter int TIMEOUT_P   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ_P-1:0]          m_req,
  input  logic [N_REQ_P-1:0]          m_rd_wr,
  input  logic [N_REQ_P*ADDR_SIZE_P-1:0] m_addr,
  input  logic [N_REQ_P*32-1:0]       m_write_val,
  output logic [N_REQ_P-1:0]          m_ack,
  output logic [N_REQ_P-1:0]          m_err,
  output logic [31:0]                 m_read_val,
  output logic                        req,
  output logic                        rd_wr,
  output logic [ADDR_SIZE_P-1:0]      addr,
  output logic [31:0]                 write_val,
  input  logic [31:0]                 read_val,
  input  logic                        ack,
  output logic [7:0]                  timeout_cnt
);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       grant, last_grant, pick_idx;
  logic                   pick_valid;
  logic [7:0]             busy_cnt;
  logic                   do_grant, do_ack, do_timeout;
  logic                   sel_rd_wr;
  logic [ADDR_SIZE_P-1:0] sel_addr;
  logic [31:0]            sel_write_val;
  logic [N_REQ_P-1:0]     grant_onehot;

  rr_pick #(.N_REQ_P(N_REQ_P)) u_rr_pick (
    .req_vec    (m_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // Mux the winner's request fields and decode the stored grant.
  always_comb begin
    sel_rd_wr     = 1'b0;
    sel_addr      = '0;
    sel_write_val = '0;
    grant_onehot  = '0;
    for (int i = 0; i < N_REQ_P; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_rd_wr     = m_rd_wr[i];
        sel_addr      = m_addr[i*ADDR_SIZE_P +: ADDR_SIZE_P];
        sel_write_val = m_write_val[i*32 +: 32];
      end
      grant_onehot[i] = (grant == IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_ack     = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          do_grant  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // ack takes priority over a timeout landing on the same edge
        if (ack) begin
          do_ack    = 1'b1;
          state_nxt = RESP;
        end else if (busy_cnt == 8'(TIMEOUT_P - 1)) begin
          do_timeout = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req         <= 1'b0;
      rd_wr       <= 1'b0;
      addr        <= '0;
      write_val   <= '0;
      m_ack       <= '0;
      m_err       <= '0;
      m_read_val  <= '0;
      timeout_cnt <= '0;
      busy_cnt    <= '0;
      grant       <= '0;
      last_grant  <= IDX_W'(N_REQ_P - 1);
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        req        <= 1'b1;
        rd_wr      <= sel_rd_wr;
        addr       <= sel_addr;
        write_val  <= sel_write_val;
        grant      <= pick_idx;
        last_grant <= pick_idx;
        busy_cnt   <= '0;
      end
      if (state == BUSY && !do_ack && !do_timeout) begin
        busy_cnt <= busy_cnt + 8'd1;
      end
      if (do_ack) begin
        req        <= 1'b0;
        m_read_val <= rd_wr ? read_val : 32'd0;
        m_ack      <= grant_onehot;
        m_err      <= '0;
      end
      if (do_timeout) begin
        req        <= 1'b0;
        m_read_val <= TIMEOUT_RDATA;
        m_ack      <= grant_onehot;
        m_err      <= grant_onehot;
        if (timeout_cnt != 8'hFF) begin
          timeout_cnt <= timeout_cnt + 8'd1;
        end
      end
      if (state == RESP) begin
        m_ack <= '0;
        m_err <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// tb/tb_reg_arbiter.sv - randomized self-checking bench for reg_arbiter
module tb_reg_arbiter;

  localparam int A = 4;
  localparam int N = 2;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   m_req, m_rd_wr, m_ack, m_err;
  logic [N*A-1:0] m_addr;
  logic [N*32-1:0] m_write_val;
  logic [31:0]    m_read_val, write_val, read_val;
  logic           req, rd_wr, ack;
  logic [A-1:0]   addr;
  logic [7:0]     timeout_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // reference state: who was granted last and how many timeouts so far
  int last_g = N - 1;
  int tcnt   = 0;
  logic [31:0] last_rval = 32'd0;

  reg_arbiter #(.ADDR_SIZE_P(A), .N_REQ_P(N), .TIMEOUT_P(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req       (m_req),
    .m_rd_wr     (m_rd_wr),
    .m_addr      (m_addr),
    .m_write_val (m_write_val),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .m_read_val  (m_read_val),
    .req         (req),
    .rd_wr       (rd_wr),
    .addr        (addr),
    .write_val   (write_val),
    .read_val    (read_val),
    .ack         (ack),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] mask);
    for (int off = 1; off <= N; off++) begin
      if (mask[(last_g + off) % N]) return (last_g + off) % N;
    end
    return -1;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      m_rd_wr[i]            = 1'($urandom);
      m_addr[i*A +: A]      = A'($urandom);
      m_write_val[i*32 +: 32] = $urandom;
    end
  endtask

  // Called at a falling edge with the arbiter idle. d = BUSY cycle on which ack
  // is pulsed (1 = first cycle req is visible); d > T means the ack never comes.
  task automatic run_txn(input logic [N-1:0] mask, input int d, input logic [31:0] rv,
                         input bit use_fix, input logic rd_fix, input logic [A-1:0] addr_fix,
                         input logic [31:0] wv_fix);
    int          w;
    logic        exp_rd;
    logic [A-1:0] exp_addr;
    logic [31:0] exp_wv, exp_rval;
    logic [N-1:0] oh;
    bit          exp_err;

    scramble_inputs();
    if (use_fix) begin
      for (int i = 0; i < N; i++) begin
        m_rd_wr[i]              = rd_fix;
        m_addr[i*A +: A]        = addr_fix;
        m_write_val[i*32 +: 32] = wv_fix;
      end
    end
    m_req    = mask;
    ack      = 1'($urandom);       // stray ack in IDLE must be ignored
    read_val = $urandom;
    w        = rr_winner(mask);
    exp_rd   = m_rd_wr[w];
    exp_addr = m_addr[w*A +: A];
    exp_wv   = m_write_val[w*32 +: 32];
    @(negedge clk);
    ack    = 1'b0;
    last_g = w;
    check_val("grant_req", 32'(req), 32'd1);

    for (int k = 1; k <= T; k++) begin
      check_val("busy_req", 32'(req), 32'd1);
      check_val("bus_rd_wr", 32'(rd_wr), 32'(exp_rd));
      check_val("bus_addr", 32'(addr), 32'(exp_addr));
      check_val("bus_wval", write_val, exp_wv);
      check_val("busy_no_ack", 32'(m_ack), 32'd0);
      scramble_inputs();
      m_req    = N'($urandom);
      ack      = (k == d);
      read_val = (k == d) ? rv : $urandom;
      @(negedge clk);
      ack = 1'b0;
      if (k == d) break;
    end

    exp_err  = (d > T);
    exp_rval = exp_err ? 32'hDEAD_BEEF : (exp_rd ? rv : 32'd0);
    if (exp_err && tcnt < 255) tcnt++;
    oh    = '0;
    oh[w] = 1'b1;
    check_val("m_ack", 32'(m_ack), 32'(oh));
    check_val("m_err", 32'(m_err), exp_err ? 32'(oh) : 32'd0);
    check_val("m_read_val", m_read_val, exp_rval);
    check_val("req_drop", 32'(req), 32'd0);
    check_val("timeout_cnt", 32'(timeout_cnt), 32'(tcnt));
    last_rval = exp_rval;

    m_req    = '0;
    ack      = 1'($urandom);       // stray ack in RESP must be ignored
    read_val = $urandom;
    @(negedge clk);
    ack = 1'b0;
    check_val("resp_end_ack", 32'(m_ack), 32'd0);
    check_val("resp_end_err", 32'(m_err), 32'd0);
    check_val("read_hold", m_read_val, last_rval);
    check_val("idle_req", 32'(req), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_req"}, 32'(req), 32'd0);
    check_val({tag, "_rd_wr"}, 32'(rd_wr), 32'd0);
    check_val({tag, "_addr"}, 32'(addr), 32'd0);
    check_val({tag, "_wval"}, write_val, 32'd0);
    check_val({tag, "_m_ack"}, 32'(m_ack), 32'd0);
    check_val({tag, "_m_err"}, 32'(m_err), 32'd0);
    check_val({tag, "_rval"}, m_read_val, 32'd0);
    check_val({tag, "_tcnt"}, 32'(timeout_cnt), 32'd0);
  endtask

  task automatic reset_mid_busy();
    scramble_inputs();
    m_req = N'($urandom_range(1, (1 << N) - 1));
    @(negedge clk);
    check_val("rst_busy_req", 32'(req), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("rst_async");
    last_g    = N - 1;
    tcnt      = 0;
    last_rval = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    m_req = '0;
    ack   = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_val("rst_stray_ack", 32'(m_ack), 32'd0);
    check_val("rst_stray_req", 32'(req), 32'd0);
    @(negedge clk);
    check_val("rst_idle_ack", 32'(m_ack), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    m_req       = '0;
    m_rd_wr     = '0;
    m_addr      = '0;
    m_write_val = '0;
    read_val    = '0;
    ack         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    run_txn(2'b01, 2, 32'h0, 1'b1, 1'b0, 4'd3, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 1, 32'h0000_00A5, 1'b1, 1'b1, (i % 2 == 0) ? 4'd1 : 4'd2, $urandom);
    end
    run_txn(2'b01, T + 5, $urandom, 1'b0, 1'b0, 4'd0, 32'd0);
    run_txn(2'b10, T, 32'hCAFE_0001, 1'b1, 1'b1, 4'd5, 32'd0);
    run_txn(2'b01, T - 1, 32'h0BAD_F00D, 1'b1, 1'b1, 4'd6, 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(1, T + 3),
              $urandom, 1'b0, 1'b0, 4'd0, 32'd0);
    end

    reset_mid_busy();
    run_txn(2'b11, 3, 32'h5555_AAAA, 1'b1, 1'b1, 4'd9, 32'd0);

    for (int i = 0; i < 260; i++) begin
      run_txn(N'($urandom_range(1, (1 << N) - 1)), T + 1, $urandom, 1'b0, 1'b0, 4'd0, 32'd0);
    end
    check_val("tcnt_saturated", 32'(timeout_cnt), 32'd255);
    run_txn(2'b11, 4, 32'h7777_0000, 1'b1, 1'b1, 4'd2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
